// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: steps one instruction at a time through the shared
// datapath, owns the single memory-port handshake, the memory watchdog and the retire counter.
module multicycle_sequencer #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run_i,
  input  logic [6:0]       opcode_i,
  input  logic             branch_taken_i,
  input  logic             mem_ready_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic             addr_sel_o,
  output logic             ir_write_o,
  output logic             pc_write_o,
  output logic             pc_src_o,
  output logic             alu_src_o,
  output logic             reg_write_o,
  output logic             mem_to_reg_o,
  output logic             busy_o,
  output logic             halt_o,
  output logic [1:0]       trap_cause_o,
  output logic [2:0]       state_o,
  output logic [CNT_W-1:0] instret_o
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam int         WD_W      = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_TRAP   = 3'd7
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] instret_q, instret_d;
  logic [1:0]       trap_cause_q, trap_cause_d;
  logic [WD_W-1:0]  wdog_q, wdog_d;
  logic             timeout;
  logic             legal_op;
  logic             imm_op;
  state_t           boundary;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      instret_q    <= '0;
      trap_cause_q <= 2'd0;
      wdog_q       <= '0;
    end else begin
      state_q      <= state_d;
      instret_q    <= instret_d;
      trap_cause_q <= trap_cause_d;
      wdog_q       <= wdog_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    trap_cause_d = trap_cause_q;
    mem_req_o    = 1'b0;
    mem_we_o     = 1'b0;
    addr_sel_o   = 1'b0;
    ir_write_o   = 1'b0;
    pc_write_o   = 1'b0;
    pc_src_o     = 1'b0;
    alu_src_o    = 1'b0;
    reg_write_o  = 1'b0;
    mem_to_reg_o = 1'b0;

    legal_op = (opcode_i == OP_R) || (opcode_i == OP_I) || (opcode_i == OP_LOAD) ||
               (opcode_i == OP_STORE) || (opcode_i == OP_BRANCH);
    imm_op   = (opcode_i == OP_I) || (opcode_i == OP_LOAD) || (opcode_i == OP_STORE);
    // The wait cycle that brings the count up to MEM_TIMEOUT abandons the request.
    timeout  = !mem_ready_i && (wdog_q == WD_W'(MEM_TIMEOUT - 1));
    boundary = run_i ? S_FETCH : S_IDLE;

    case (state_q)
      S_IDLE: begin
        if (run_i) state_d = S_FETCH;
      end
      S_FETCH: begin
        mem_req_o = 1'b1;
        if (mem_ready_i) begin
          ir_write_o = 1'b1;
          state_d    = S_DECODE;
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'd2;
        end
      end
      S_DECODE: begin
        if (legal_op) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_TRAP;
          trap_cause_d = 2'd1;
        end
      end
      S_EXEC: begin
        alu_src_o = imm_op;
        if (opcode_i == OP_BRANCH) begin
          pc_write_o = 1'b1;
          pc_src_o   = branch_taken_i;
          state_d    = boundary;
        end else if ((opcode_i == OP_LOAD) || (opcode_i == OP_STORE)) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req_o  = 1'b1;
        addr_sel_o = 1'b1;
        mem_we_o   = (opcode_i == OP_STORE);
        alu_src_o  = 1'b1;
        if (mem_ready_i) begin
          if (opcode_i == OP_STORE) begin
            pc_write_o = 1'b1;
            state_d    = boundary;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout) begin
          state_d      = S_TRAP;
          trap_cause_d = 2'd2;
        end
      end
      S_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = (opcode_i == OP_LOAD);
        pc_write_o   = 1'b1;
        state_d      = boundary;
      end
      S_TRAP: begin
        state_d = S_TRAP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    wdog_d    = (mem_req_o && !mem_ready_i && (state_d == state_q)) ? wdog_q + WD_W'(1) : '0;
    instret_d = pc_write_o ? instret_q + CNT_W'(1) : instret_q;
  end

  assign busy_o       = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign halt_o       = (state_q == S_TRAP);
  assign trap_cause_o = trap_cause_q;
  assign state_o      = state_q;
  assign instret_o    = instret_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: walks each instruction class, the memory
// handshake, reset, both trap causes and instret wrap with hand-computed expectations.
module tb_multicycle_sequencer;

  logic       clk;
  logic       rst_n;
  logic       run_i;
  logic [6:0] opcode_i;
  logic       branch_taken_i;
  logic       mem_ready_i;
  logic       mem_req_o, mem_we_o, addr_sel_o, ir_write_o, pc_write_o, pc_src_o;
  logic       alu_src_o, reg_write_o, mem_to_reg_o, busy_o, halt_o;
  logic [1:0] trap_cause_o;
  logic [2:0] state_o;
  logic [3:0] instret_o;

  int checks_q   = 0;
  int failures_q = 0;

  multicycle_sequencer #(.CNT_W(4), .MEM_TIMEOUT(4)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .run_i          (run_i),
    .opcode_i       (opcode_i),
    .branch_taken_i (branch_taken_i),
    .mem_ready_i    (mem_ready_i),
    .mem_req_o      (mem_req_o),
    .mem_we_o       (mem_we_o),
    .addr_sel_o     (addr_sel_o),
    .ir_write_o     (ir_write_o),
    .pc_write_o     (pc_write_o),
    .pc_src_o       (pc_src_o),
    .alu_src_o      (alu_src_o),
    .reg_write_o    (reg_write_o),
    .mem_to_reg_o   (mem_to_reg_o),
    .busy_o         (busy_o),
    .halt_o         (halt_o),
    .trap_cause_o   (trap_cause_o),
    .state_o        (state_o),
    .instret_o      (instret_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_q++;
    if (got !== exp) begin
      failures_q++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // Advance one clock; inputs set after this return are seen in the new state.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    run_i = 1'b0;
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n = 1'b0; run_i = 1'b0; opcode_i = 7'h00; branch_taken_i = 1'b0; mem_ready_i = 1'b0;
    #12;
    chk("rst_state", 32'(state_o), 32'd0);
    chk("rst_mem_req", 32'(mem_req_o), 32'd0);
    chk("rst_instret", 32'(instret_o), 32'd0);
    chk("rst_busy_halt", {30'd0, busy_o, halt_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();
    chk("idle_hold", 32'(state_o), 32'd0);

    // R-type 0x0020C1B3, zero-wait memory
    opcode_i = 7'h33; mem_ready_i = 1'b1; run_i = 1'b1;
    tick(); chk("r_fetch", 32'(state_o), 32'd1);
    chk("r_fetch_strb", {29'd0, mem_req_o, ir_write_o, addr_sel_o}, 32'b110);
    tick(); chk("r_decode", 32'(state_o), 32'd2);
    chk("r_decode_req", 32'(mem_req_o), 32'd0);
    tick(); chk("r_exec", 32'(state_o), 32'd3);
    chk("r_exec_strb", {29'd0, reg_write_o, alu_src_o, pc_write_o}, 32'b000);
    tick(); chk("r_wb", 32'(state_o), 32'd5);
    chk("r_wb_strb", {29'd0, reg_write_o, pc_write_o, mem_to_reg_o}, 32'b110);
    chk("r_instret_pre", 32'(instret_o), 32'd0);
    run_i = 1'b0;
    tick(); chk("r_idle", 32'(state_o), 32'd0);
    chk("r_instret", 32'(instret_o), 32'd1);

    // Load with three wait cycles in MEM
    opcode_i = 7'h03; run_i = 1'b1;
    tick(); tick();
    tick(); chk("ld_exec_alusrc", 32'(alu_src_o), 32'd1);
    mem_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ld_wait%0d", i), {28'd0, state_o, mem_req_o}, {28'd0, 3'd4, 1'b1});
      chk($sformatf("ld_wait%0d_sel", i), {29'd0, addr_sel_o, mem_we_o, pc_write_o}, 32'b100);
    end
    tick(); mem_ready_i = 1'b1;
    chk("ld_mem_last", {28'd0, state_o, mem_req_o}, {28'd0, 3'd4, 1'b1});
    tick(); chk("ld_wb", 32'(state_o), 32'd5);
    chk("ld_wb_strb", {29'd0, reg_write_o, mem_to_reg_o, pc_write_o}, 32'b111);
    run_i = 1'b0;
    tick(); chk("ld_instret", 32'(instret_o), 32'd2);

    // Branch taken, then not taken back-to-back
    opcode_i = 7'h63; branch_taken_i = 1'b1; run_i = 1'b1;
    tick(); tick(); tick();
    chk("br_t_exec", {28'd0, state_o, 1'b0}, {28'd0, 3'd3, 1'b0});
    chk("br_t_strb", {29'd0, pc_write_o, pc_src_o, reg_write_o}, 32'b110);
    branch_taken_i = 1'b0;
    tick(); chk("br_t_next_fetch", 32'(state_o), 32'd1);
    chk("br_t_instret", 32'(instret_o), 32'd3);
    tick(); tick();
    chk("br_n_strb", {29'd0, pc_write_o, pc_src_o, reg_write_o}, 32'b100);
    run_i = 1'b0;
    tick(); chk("br_n_idle", {28'd0, state_o, 1'b0}, 32'd0);
    chk("br_n_instret", 32'(instret_o), 32'd4);

    // Store, zero-wait
    opcode_i = 7'h23; run_i = 1'b1;
    tick(); tick(); tick(); tick();
    chk("st_mem", 32'(state_o), 32'd4);
    chk("st_strb", {28'd0, mem_we_o, addr_sel_o, pc_write_o, reg_write_o}, 32'b1110);
    run_i = 1'b0;
    tick(); chk("st_idle", 32'(state_o), 32'd0);
    chk("st_instret", 32'(instret_o), 32'd5);

    // Asynchronous reset in the middle of a waiting store
    run_i = 1'b1;
    tick(); tick(); mem_ready_i = 1'b0;
    tick(); tick();
    chk("rmid_mem", {28'd0, state_o, mem_req_o}, {28'd0, 3'd4, 1'b1});
    #2 rst_n = 1'b0; run_i = 1'b0;
    #1;
    chk("rmid_req", 32'(mem_req_o), 32'd0);
    chk("rmid_state", 32'(state_o), 32'd0);
    chk("rmid_instret", 32'(instret_o), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    tick(); chk("rmid_hold", 32'(state_o), 32'd0);

    // 16 back-to-back I-type ops; run drops during the 16th
    opcode_i = 7'h13; mem_ready_i = 1'b1; run_i = 1'b1;
    tick();
    for (int k = 0; k < 15; k++) begin
      tick(); tick(); tick(); tick();
    end
    chk("wr_fetch16", 32'(state_o), 32'd1);
    chk("wr_instret15", 32'(instret_o), 32'd15);
    run_i = 1'b0;
    tick(); chk("wr_decode", 32'(state_o), 32'd2);
    tick(); chk("wr_exec_alusrc", 32'(alu_src_o), 32'd1);
    tick(); chk("wr_wb", {28'd0, state_o, pc_write_o}, {28'd0, 3'd5, 1'b1});
    tick(); chk("wr_idle", 32'(state_o), 32'd0);
    chk("wr_instret0", 32'(instret_o), 32'd0);

    // Illegal opcode
    opcode_i = 7'h7F; run_i = 1'b1;
    tick(); tick();
    chk("ill_decode_pcw", 32'(pc_write_o), 32'd0);
    tick(); chk("ill_trap", 32'(state_o), 32'd7);
    chk("ill_flags", {28'd0, halt_o, busy_o, trap_cause_o}, 32'b1001);
    tick(); chk("ill_hold", {28'd0, state_o, pc_write_o}, {28'd0, 3'd7, 1'b0});
    chk("ill_instret", 32'(instret_o), 32'd0);

    do_reset();
    chk("trap_clear", {28'd0, state_o[1:0], trap_cause_o}, 32'd0);

    // Fetch that never completes
    opcode_i = 7'h33; mem_ready_i = 1'b0; run_i = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) tick();
    chk("to_wait4", {28'd0, state_o, mem_req_o}, {28'd0, 3'd1, 1'b1});
    tick(); chk("to_trap", 32'(state_o), 32'd7);
    chk("to_cause", {29'd0, halt_o, trap_cause_o}, 32'b110);
    chk("to_req_drop", 32'(mem_req_o), 32'd0);
    mem_ready_i = 1'b1;
    tick(); chk("to_hold", {28'd0, state_o, ir_write_o}, {28'd0, 3'd7, 1'b0});

    $display("TB_RESULT checks=%0d failures=%0d", checks_q, failures_q);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
